// File: rtl/afifo_r_unpacker_if.sv
// afifo_r_unpacker_if: FIFO read port plus NASTI R-channel beat bundle.
// master = unpacker side, slave = FIFO/downstream side.
interface afifo_r_unpacker_if #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_ID_WIDTH   = 4
) ();
  logic [C_DATA_WIDTH-1:0] fifo_rdata;
  logic                    fifo_rempty;
  logic                    fifo_rden;
  logic                    r_valid;
  logic                    r_ready;
  logic [C_ID_WIDTH-1:0]   r_id;
  logic [C_DATA_WIDTH-1:0] r_data;
  logic                    r_last;

  modport master (
    input  fifo_rdata, fifo_rempty, r_ready,
    output fifo_rden, r_valid, r_id, r_data, r_last
  );

  modport slave (
    output fifo_rdata, fifo_rempty, r_ready,
    input  fifo_rden, r_valid, r_id, r_data, r_last
  );
endinterface

// File: rtl/afifo_r_unpacker.sv
// afifo_r_unpacker: drains header-framed bursts from an FWFT FIFO into R beats.
// Optional AFIFO_R_UNPACKER_STATS_EN adds burst_cnt/beat_cnt counters.
module afifo_r_unpacker #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_ID_WIDTH   = 4,
  parameter int C_LEN_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst,
  afifo_r_unpacker_if.master io
`ifdef AFIFO_R_UNPACKER_STATS_EN
  ,
  output logic [31:0] burst_cnt,
  output logic [31:0] beat_cnt
`endif
);

  typedef enum logic {HDR, DAT} state_t;

  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t state_q, state_d;

  logic [C_ID_WIDTH-1:0]   id_q;
  logic [C_LEN_WIDTH-1:0]  rem_q;

  logic [C_DATA_WIDTH-1:0] d0_q, d1_q;
  logic [C_ID_WIDTH-1:0]   i0_q, i1_q;
  logic                    l0_q, l1_q;
  logic [1:0]              cnt_q;

  logic       rden;
  logic       push;
  logic       hdr_pop;
  logic       pop;
  logic [1:0] cnt_drained;
  logic       new_last;

  assign pop         = (cnt_q != 2'd0) & io.r_ready;
  assign cnt_drained = cnt_q - {1'b0, pop};
  assign push        = rden & (state_q == DAT);
  assign hdr_pop     = rden & (state_q == HDR);
  assign new_last    = (rem_q == '0);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HDR;
    else     state_q <= state_d;
  end

  // Next state and FIFO pop strobe
  always_comb begin
    state_d = state_q;
    rden    = 1'b0;
    unique case (state_q)
      HDR: begin
        rden = ~io.fifo_rempty & ~rst;
        if (rden) state_d = DAT;
      end
      DAT: begin
        rden = ~io.fifo_rempty
             & (cnt_drained < 2'd2)
             & ~rst;
        if (rden && new_last) state_d = HDR;
      end
      default: ;
    endcase
  end

  // Header fields and remaining-beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q  <= '0;
      rem_q <= '0;
    end else if (hdr_pop) begin
      id_q  <= io.fifo_rdata[C_LEN_WIDTH +: C_ID_WIDTH];
      rem_q <= io.fifo_rdata[C_LEN_WIDTH-1:0];
    end else if (push && !new_last) begin
      rem_q <= rem_q - LEN_ONE;
    end
  end

  // Two-entry skid buffer, entry 0 is the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q  <= '0;
      d1_q  <= '0;
      i0_q  <= '0;
      i1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            d0_q <= io.fifo_rdata;
            i0_q <= id_q;
            l0_q <= new_last;
          end else begin
            d1_q <= io.fifo_rdata;
            i1_q <= id_q;
            l1_q <= new_last;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          i0_q  <= i1_q;
          l0_q  <= l1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_q <= io.fifo_rdata;
            i0_q <= id_q;
            l0_q <= new_last;
          end else begin
            d0_q <= d1_q;
            i0_q <= i1_q;
            l0_q <= l1_q;
            d1_q <= io.fifo_rdata;
            i1_q <= id_q;
            l1_q <= new_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.fifo_rden = rden;
  assign io.r_valid   = (cnt_q != 2'd0);
  assign io.r_data    = d0_q;
  assign io.r_id      = i0_q;
  assign io.r_last    = l0_q;

`ifdef AFIFO_R_UNPACKER_STATS_EN
  // Accepted beat and burst counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= 32'd0;
      burst_cnt <= 32'd0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (l0_q) burst_cnt <= burst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_afifo_r_unpacker.sv
// tb_afifo_r_unpacker: directed bench with a queue-based FWFT FIFO model.
// Beats accepted downstream are recorded and compared to hand values.
module tb_afifo_r_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  afifo_r_unpacker_if #(.C_DATA_WIDTH(64), .C_ID_WIDTH(4)) bus ();

`ifdef AFIFO_R_UNPACKER_STATS_EN
  logic [31:0] burst_cnt, beat_cnt;
`endif

  afifo_r_unpacker #(
    .C_DATA_WIDTH(64),
    .C_ID_WIDTH(4),
    .C_LEN_WIDTH(8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
`ifdef AFIFO_R_UNPACKER_STATS_EN
    ,
    .burst_cnt(burst_cnt),
    .beat_cnt(beat_cnt)
`endif
  );

  logic [63:0] q[$];
  logic [63:0] bd[$];
  logic [3:0]  bi[$];
  logic        bl[$];
  int          bc[$];
  logic        gap;
  logic        rd;
  logic        vld;
  int          cyc;
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] hw(input int id, input int len);
    return (64'hABCD << 32) | (64'(id) << 8) | 64'(len);
  endfunction

  task automatic tick();
    bus.fifo_rempty = gap || (q.size() == 0);
    bus.fifo_rdata  = (q.size() != 0) ? q[0] : 64'd0;
    #1;
    rd  = bus.fifo_rden;
    vld = bus.r_valid;
    if (bus.r_valid && bus.r_ready) begin
      bd.push_back(bus.r_data);
      bi.push_back(bus.r_id);
      bl.push_back(bus.r_last);
      bc.push_back(cyc);
    end
    @(posedge clk);
    if (rd && q.size() != 0) void'(q.pop_front());
    @(negedge clk);
    cyc++;
  endtask

  task automatic clr();
    bd.delete();
    bi.delete();
    bl.delete();
    bc.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (bd.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("beat_count", 64'(bd.size()), 64'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int c0;
    int stall_rd;
    int novld;
    int nv;
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    gap     = 1'b0;
    rd      = 1'b0;
    vld     = 1'b0;
    bus.r_ready     = 1'b0;
    bus.fifo_rempty = 1'b1;
    bus.fifo_rdata  = 64'd0;
    @(negedge clk);

    // reset state, FIFO non-empty but must not be popped
    q.push_back(64'h55);
    tick();
    tick();
    chk("rst_rden", 64'(rd), 64'd0);
    chk("rst_valid", 64'(bus.r_valid), 64'd0);
    chk("rst_last", 64'(bus.r_last), 64'd0);
    chk("rst_id", 64'(bus.r_id), 64'd0);
    chk("rst_data", bus.r_data, 64'd0);
    chk("rst_nopop", 64'(q.size()), 64'd1);
    q.delete();
    rst = 1'b0;
    idle(2);

    // T1: id=3 len=3
    clr();
    bus.r_ready = 1'b1;
    q.push_back(hw(3, 3));
    for (int i = 0; i < 4; i++) q.push_back(64'h1000 + 64'(i));
    c0 = cyc;
    wait_beats(4, 30);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), bd[i], 64'h1000 + 64'(i));
      chk($sformatf("t1_id%0d", i), 64'(bi[i]), 64'd3);
      chk($sformatf("t1_last%0d", i), 64'(bl[i]), 64'(i == 3));
    end
    chk("t1_latency", 64'(bc[0] - c0), 64'd2);
    chk("t1_tput", 64'(bc[3] - bc[0]), 64'd3);
    idle(3);

    // T2: single-beat burst then id=6 len=1
    clr();
    q.push_back(hw(5, 0));
    q.push_back(64'h2000);
    q.push_back(hw(6, 1));
    q.push_back(64'h2100);
    q.push_back(64'h2101);
    wait_beats(3, 30);
    chk("t2_data0", bd[0], 64'h2000);
    chk("t2_id0", 64'(bi[0]), 64'd5);
    chk("t2_last0", 64'(bl[0]), 64'd1);
    chk("t2_data1", bd[1], 64'h2100);
    chk("t2_id1", 64'(bi[1]), 64'd6);
    chk("t2_last1", 64'(bl[1]), 64'd0);
    chk("t2_data2", bd[2], 64'h2101);
    chk("t2_last2", 64'(bl[2]), 64'd1);
    idle(3);

    // T3: stall after the first beat of an 8-beat burst
    clr();
    q.push_back(hw(1, 7));
    for (int i = 0; i < 8; i++) q.push_back(64'h3000 + 64'(i));
    wait_beats(1, 20);
    bus.r_ready = 1'b0;
    stall_rd = 0;
    novld    = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k >= 1 && rd) stall_rd++;
      if (!vld) novld++;
    end
    chk("t3_stall_rden", 64'(stall_rd), 64'd0);
    chk("t3_stall_valid", 64'(novld), 64'd0);
    chk("t3_stall_data", bus.r_data, 64'h3001);
    chk("t3_stall_beats", 64'(bd.size()), 64'd1);
    bus.r_ready = 1'b1;
    wait_beats(8, 40);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_data%0d", i), bd[i], 64'h3000 + 64'(i));
      chk($sformatf("t3_last%0d", i), 64'(bl[i]), 64'(i == 7));
    end
    for (int i = 2; i < 8; i++)
      chk($sformatf("t3_gap%0d", i), 64'(bc[i] - bc[i-1]), 64'd1);
    idle(3);

    // T4: FIFO runs empty after D1
    clr();
    q.push_back(hw(2, 3));
    q.push_back(64'h4000);
    q.push_back(64'h4001);
    c0 = 0;
    while (q.size() != 0 && c0 < 20) begin
      tick();
      c0++;
    end
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (vld) nv++;
    end
    chk("t4_gap_valid", 64'(nv), 64'd1);
    chk("t4_gap_beats", 64'(bd.size()), 64'd2);
    q.push_back(64'h4002);
    q.push_back(64'h4003);
    wait_beats(4, 30);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_data%0d", i), bd[i], 64'h4000 + 64'(i));
      chk($sformatf("t4_id%0d", i), 64'(bi[i]), 64'd2);
      chk($sformatf("t4_last%0d", i), 64'(bl[i]), 64'(i == 3));
    end
    idle(3);

    // T5: reset in the middle of a burst
    clr();
    q.push_back(hw(4, 3));
    for (int i = 0; i < 4; i++) q.push_back(64'h5000 + 64'(i));
    wait_beats(2, 20);
    rst = 1'b1;
    tick();
    chk("t5_rst_rden", 64'(rd), 64'd0);
    chk("t5_rst_valid", 64'(bus.r_valid), 64'd0);
    chk("t5_rst_last", 64'(bus.r_last), 64'd0);
    chk("t5_rst_id", 64'(bus.r_id), 64'd0);
    chk("t5_rst_data", bus.r_data, 64'd0);
    q.delete();
    clr();
    rst = 1'b0;
    q.push_back(hw(7, 1));
    q.push_back(64'h6a);
    q.push_back(64'h6b);
    wait_beats(2, 20);
    chk("t5_data0", bd[0], 64'h6a);
    chk("t5_id0", 64'(bi[0]), 64'd7);
    chk("t5_last0", 64'(bl[0]), 64'd0);
    chk("t5_data1", bd[1], 64'h6b);
    chk("t5_id1", 64'(bi[1]), 64'd7);
    chk("t5_last1", 64'(bl[1]), 64'd1);
    idle(3);

`ifdef AFIFO_R_UNPACKER_STATS_EN
    // T6: counters over 3 bursts with a toggling r_ready
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    for (int b = 0; b < 3; b++) begin
      q.push_back(hw(b, 1));
      q.push_back(64'h7000 + 64'(2 * b));
      q.push_back(64'h7001 + 64'(2 * b));
    end
    for (int k = 0; k < 40; k++) begin
      bus.r_ready = k[0];
      tick();
    end
    bus.r_ready = 1'b1;
    idle(4);
    chk("t6_beats", 64'(bd.size()), 64'd6);
    chk("t6_burst_cnt", 64'(burst_cnt), 64'd3);
    chk("t6_beat_cnt", 64'(beat_cnt), 64'd6);
    rst = 1'b1;
    tick();
    chk("t6_rst_burst", 64'(burst_cnt), 64'd0);
    chk("t6_rst_beat", 64'(beat_cnt), 64'd0);
    rst = 1'b0;
    idle(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
